// File: rtl/sun_apb_master.sv
// sun_apb_master: APB master sequencing one sun sensor measurement.
// On an accepted start it writes four config bytes (0x1..0x4), writes the start
// command (0x0 = 0x1), polls status at 0x0 until bit1 (done) is set, reads the
// result from 0x5 and presents it with a one-cycle sample_valid pulse. A
// conversion timeout aborts polling with a one-cycle timeout_err pulse.
// Ports:
//   pclk, presetn                 clock, async active-low reset
//   start, cfg_data               measurement request and config bytes
//   psel, penable, pwrite,
//   paddr, pwdata, prdata, pready APB master interface
//   busy                          measurement in progress
//   sample_data, sample_valid     last result and its update strobe
//   timeout_err                   conversion timeout strobe
module sun_apb_master #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned POLL_GAP = 4,
  parameter int unsigned TIMEOUT  = 1024
) (
  input  logic              pclk,
  input  logic              presetn,
  input  logic              start,
  input  logic [31:0]       cfg_data,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  output logic              busy,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              timeout_err
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_CFG  = 3'd1;
  localparam logic [2:0] ST_GO   = 3'd2;
  localparam logic [2:0] ST_POLL = 3'd3;
  localparam logic [2:0] ST_GAP  = 3'd4;
  localparam logic [2:0] ST_RES  = 3'd5;
  localparam logic [2:0] ST_DONE = 3'd6;
  localparam logic [2:0] ST_ERR  = 3'd7;

  // Transfer phase inside CFG/GO/POLL/RES; PH_IDLE is the mandatory bus-idle
  // cycle after a completed transfer.
  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_ACCESS = 2'd1;
  localparam logic [1:0] PH_IDLE   = 2'd2;

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam int unsigned GW = $clog2(POLL_GAP + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'(POLL_GAP - 1);

  logic [2:0]        state_q, state_d;
  logic [1:0]        phase_q, phase_d;
  logic [1:0]        idx_q, idx_d;
  logic [31:0]       cfg_q, cfg_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [DATA_W-1:0] sample_data_q, sample_data_d;

  logic       xfer_st;
  logic       tmo_hit;
  logic [7:0] cfg_byte;

  assign xfer_st = (state_q == ST_CFG) || (state_q == ST_GO) ||
                   (state_q == ST_POLL) || (state_q == ST_RES);
  assign tmo_hit = (tmo_q >= TMO_LAST);

  always_comb begin
    cfg_byte = cfg_q[7:0];
    case (idx_q)
      2'd1:    cfg_byte = cfg_q[15:8];
      2'd2:    cfg_byte = cfg_q[23:16];
      2'd3:    cfg_byte = cfg_q[31:24];
      default: cfg_byte = cfg_q[7:0];
    endcase
  end

  // Bus outputs are pure decodes of state, so they hold from SETUP through
  // ACCESS and drop asynchronously with reset.
  always_comb begin
    psel         = xfer_st && (phase_q != PH_IDLE);
    penable      = xfer_st && (phase_q == PH_ACCESS);
    pwrite       = 1'b0;
    paddr        = '0;
    pwdata       = '0;
    busy         = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);
    sample_valid = (state_q == ST_DONE);
    timeout_err  = (state_q == ST_ERR);
    sample_data  = sample_data_q;
    case (state_q)
      ST_CFG: begin
        pwrite      = 1'b1;
        paddr[2:0]  = {1'b0, idx_q} + 3'd1;
        pwdata[7:0] = cfg_byte;
      end
      ST_GO: begin
        pwrite    = 1'b1;
        pwdata[0] = 1'b1;
      end
      ST_RES:  paddr[2:0] = 3'd5;
      default: ;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    idx_d         = idx_q;
    cfg_d         = cfg_q;
    tmo_d         = tmo_q;
    gap_d         = gap_q;
    res_d         = res_q;
    sample_data_d = sample_data_q;

    if (((state_q == ST_POLL) || (state_q == ST_GAP)) && !tmo_hit) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cfg_d   = cfg_data;
          idx_d   = '0;
          phase_d = PH_SETUP;
          state_d = ST_CFG;
        end
      end
      ST_CFG, ST_GO, ST_POLL, ST_RES: begin
        case (phase_q)
          PH_SETUP: begin
            // Timeout is only honoured outside an active access.
            if ((state_q == ST_POLL) && tmo_hit) begin
              state_d = ST_ERR;
            end else begin
              phase_d = PH_ACCESS;
            end
          end
          PH_ACCESS: begin
            if (pready) begin
              phase_d = PH_IDLE;
              if (state_q == ST_GO) begin
                tmo_d = '0;
              end
              if (state_q == ST_RES) begin
                res_d = prdata;
              end
              // Not done: the GAP idle cycles double as the post-transfer idle.
              if ((state_q == ST_POLL) && !prdata[1]) begin
                state_d = ST_GAP;
                gap_d   = '0;
              end
            end
          end
          default: begin
            phase_d = PH_SETUP;
            case (state_q)
              ST_CFG: begin
                if (idx_q == 2'd3) begin
                  state_d = ST_GO;
                end else begin
                  idx_d = idx_q + 2'd1;
                end
              end
              ST_GO:   state_d = ST_POLL;
              ST_POLL: state_d = ST_RES;
              default: begin
                state_d       = ST_DONE;
                sample_data_d = res_q;
              end
            endcase
          end
        endcase
      end
      ST_GAP: begin
        if (tmo_hit) begin
          state_d = ST_ERR;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_POLL;
          phase_d = PH_SETUP;
        end else begin
          gap_d = gap_q + GW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q       <= ST_IDLE;
      phase_q       <= PH_SETUP;
      idx_q         <= '0;
      cfg_q         <= '0;
      tmo_q         <= '0;
      gap_q         <= '0;
      res_q         <= '0;
      sample_data_q <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      idx_q         <= idx_d;
      cfg_q         <= cfg_d;
      tmo_q         <= tmo_d;
      gap_q         <= gap_d;
      res_q         <= res_d;
      sample_data_q <= sample_data_d;
    end
  end

endmodule

// File: tb/tb_sun_apb_master.sv
// tb_sun_apb_master: scoreboard bench for sun_apb_master. Each measurement
// pushes its expected APB transfers and result/timeout events into a queue; a
// negedge monitor (which also models the sun sensor slave) pops and compares
// whenever the DUT completes a transfer or pulses sample_valid/timeout_err.
module tb_sun_apb_master;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned POLL_GAP = 4;
  localparam int unsigned TIMEOUT  = 64;

  logic              pclk     = 1'b0;
  logic              presetn  = 1'b0;
  logic              start    = 1'b0;
  logic [31:0]       cfg_data = '0;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic              pready   = 1'b1;
  logic              busy;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid, timeout_err;

  always #5 pclk = ~pclk;

  sun_apb_master #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .POLL_GAP(POLL_GAP),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .pclk        (pclk),
    .presetn     (presetn),
    .start       (start),
    .cfg_data    (cfg_data),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .prdata      (prdata),
    .pready      (pready),
    .busy        (busy),
    .sample_data (sample_data),
    .sample_valid(sample_valid),
    .timeout_err (timeout_err)
  );

  // kind: 0 = APB transfer, 1 = sample_valid pulse, 2 = timeout_err pulse
  typedef struct {
    int          kind;
    bit          w;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  int          polls_done = 0;
  int          base_polls = 0;
  int          done_on = 0;
  logic [31:0] res_val = '0;
  int          meas_id = 0;
  int          cur_id = 0;
  int          stall_left = 0;
  int          stall_len = 0;
  logic [31:0] stall_addr = '1;
  bit          in_stall = 1'b0;
  int          last_poll = -1;
  int          sv_cnt = 0;
  int          start_cyc = 0;
  bit          chk_lat = 1'b0;
  logic [31:0] h_addr, h_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input bit w, input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.kind = kind;
    e.w    = w;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic unexpected(input string what);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got an unexpected DUT event, expected none", what);
  endtask

  // Sensor slave: status done once the poll count reaches done_on (0 = never).
  always_comb begin
    prdata = '0;
    if (paddr == 32'h5) begin
      prdata = res_val;
    end else if ((paddr == 32'h0) && (done_on != 0) && ((polls_done - base_polls) >= done_on)) begin
      prdata = 32'h2;
    end
  end

  always @(posedge pclk) cyc <= cyc + 1;

  always @(negedge pclk) begin : mon
    exp_t e;
    if (meas_id != cur_id) begin
      cur_id     = meas_id;
      stall_left = stall_len;
      last_poll  = -1;
      in_stall   = 1'b0;
    end
    if (!presetn) begin
      pready   = 1'b1;
      in_stall = 1'b0;
    end else begin
      if ((stall_left > 0) && (in_stall || (psel && penable && (paddr == stall_addr)))) begin
        if (!in_stall) begin
          in_stall = 1'b1;
          h_addr   = paddr;
          h_wdata  = pwdata;
        end else begin
          chk("stall psel", 32'(psel), 32'd1);
          chk("stall penable", 32'(penable), 32'd1);
          chk("stall pwrite", 32'(pwrite), 32'd1);
          chk("stall paddr", paddr, h_addr);
          chk("stall pwdata", pwdata, h_wdata);
        end
        pready = 1'b0;
        stall_left--;
      end else begin
        in_stall = 1'b0;
        pready   = 1'b1;
      end

      if (psel && penable && pready) begin
        if (exp_q.size() == 0) begin
          unexpected("apb transfer");
        end else begin
          e = exp_q.pop_front();
          chk("event kind (xfer)", 32'd0, 32'(e.kind));
          chk("pwrite", 32'(pwrite), 32'(e.w));
          chk("paddr", paddr, e.addr);
          if (e.w) chk("pwdata", pwdata, e.data);
        end
        if (!pwrite && (paddr == 32'h0)) begin
          polls_done++;
          if (last_poll >= 0) chk("poll spacing", 32'(cyc - last_poll), 32'(POLL_GAP + 2));
          last_poll = cyc;
        end
      end

      if (sample_valid) begin
        sv_cnt++;
        if (exp_q.size() == 0) begin
          unexpected("sample_valid");
        end else begin
          e = exp_q.pop_front();
          chk("event kind (sample)", 32'd1, 32'(e.kind));
          chk("sample_data", sample_data, e.data);
          chk("busy at done", 32'(busy), 32'd0);
          if (chk_lat) chk("start to valid latency", 32'(cyc - start_cyc), 32'd22);
        end
      end

      if (timeout_err) begin
        if (exp_q.size() == 0) begin
          unexpected("timeout_err");
        end else begin
          e = exp_q.pop_front();
          chk("event kind (timeout)", 32'd2, 32'(e.kind));
          chk("busy at timeout", 32'(busy), 32'd0);
        end
      end
    end
  end

  task automatic push_prologue(input logic [31:0] cfg, input int polls);
    for (int i = 0; i < 4; i++) push(0, 1'b1, 32'(i + 1), (cfg >> (8 * i)) & 32'hFF);
    push(0, 1'b1, 32'h0, 32'h1);
    for (int i = 0; i < polls; i++) push(0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic run_meas(input logic [31:0] cfg, input int d_on, input logic [31:0] res,
                          input logic [31:0] s_addr, input int s_len, input int polls,
                          input bit tmo, input bit lat, input bit extra);
    int k;
    done_on    = d_on;
    res_val    = res;
    base_polls = polls_done;
    stall_addr = s_addr;
    stall_len  = s_len;
    chk_lat    = lat;
    push_prologue(cfg, polls);
    if (!tmo) begin
      push(0, 1'b0, 32'h5, 32'h0);
      push(1, 1'b0, 32'h0, res);
    end else begin
      push(2, 1'b0, 32'h0, 32'h0);
    end
    meas_id++;
    cfg_data  = cfg;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge pclk);
    start = 1'b0;
    chk("busy after start", 32'(busy), 32'd1);
    k = 0;
    while (busy && (k < 600)) begin
      @(negedge pclk);
      k++;
      start = extra && ((k == 4) || (k == 10));
    end
    start = 1'b0;
    if (k >= 600) begin
      n_cmp++;
      n_bad++;
      $display("FAIL measurement end: busy still 1 after %0d cycles, expected 0", k);
    end
    repeat (3) @(negedge pclk);
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int k;
    int sv0;
    repeat (3) @(negedge pclk);
    chk("reset psel", 32'(psel), 32'd0);
    chk("reset penable", 32'(penable), 32'd0);
    chk("reset pwrite", 32'(pwrite), 32'd0);
    chk("reset paddr", paddr, 32'd0);
    chk("reset pwdata", pwdata, 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset sample_data", sample_data, 32'd0);
    chk("reset sample_valid", 32'(sample_valid), 32'd0);
    chk("reset timeout_err", 32'(timeout_err), 32'd0);
    presetn = 1'b1;
    repeat (2) @(negedge pclk);

    // Config byte order, minimum latency with done on first poll.
    run_meas(32'h1BFFFF0F, 1, 32'hCAFE0001, '1, 0, 1, 1'b0, 1'b1, 1'b0);
    // Done on third poll.
    run_meas(32'hA5A5A5A5, 3, 32'h00001234, '1, 0, 3, 1'b0, 1'b0, 1'b0);
    repeat (5) @(negedge pclk);
    chk("sample_data held", sample_data, 32'h00001234);
    // Five wait states on the write to 0x2.
    run_meas(32'h11223344, 1, 32'h000055AA, 32'h2, 5, 1, 1'b0, 1'b0, 1'b0);
    chk("stall consumed", 32'(stall_left), 32'd0);
    // Never done: timeout after 11 polls, no result read.
    run_meas(32'h01020304, 0, 32'hDEADBEEF, '1, 0, 11, 1'b1, 1'b0, 1'b0);
    chk("sample_data after timeout", sample_data, 32'h000055AA);
    // Extra start pulses while busy are ignored.
    sv0 = sv_cnt;
    run_meas(32'h0F0E0D0C, 2, 32'h0000BEEF, '1, 0, 2, 1'b0, 1'b0, 1'b1);
    chk("one sample per start", 32'(sv_cnt - sv0), 32'd1);

    // Reset during the first status poll access.
    done_on    = 0;
    base_polls = polls_done;
    stall_len  = 0;
    chk_lat    = 1'b0;
    push_prologue(32'h44332211, 1);
    meas_id++;
    cfg_data = 32'h44332211;
    start    = 1'b1;
    @(negedge pclk);
    start = 1'b0;
    k = 0;
    while (!(psel && penable && !pwrite && (paddr == 32'h0)) && (k < 100)) begin
      @(negedge pclk);
      k++;
    end
    if (k >= 100) begin
      n_cmp++;
      n_bad++;
      $display("FAIL poll access wait: no status read after %0d cycles, expected one", k);
    end
    #2 presetn = 1'b0;
    #1;
    chk("mid-reset psel", 32'(psel), 32'd0);
    chk("mid-reset penable", 32'(penable), 32'd0);
    chk("mid-reset busy", 32'(busy), 32'd0);
    repeat (2) @(negedge pclk);
    chk("abandoned scoreboard", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    presetn = 1'b1;
    @(negedge pclk);
    run_meas(32'h44332211, 1, 32'h00000BAD, '1, 0, 1, 1'b0, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
